seq_detector_prog: RTL



---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_det_window.sv | 50 +++++
 rtl/seq_detector_prog.sv | 112 +++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// The defaults reproduce the legacy fixed 1101 overlapping detector.
package seq_det_pkg;

  localparam logic [31:0] DEF_PATTERN = 32'b1101;
  localparam int          DEF_LEN     = 4;
  localparam logic        DEF_OVERLAP = 1'b1;

  // Maps a requested pattern length onto the usable range 1..max_len.
  function automatic int clamp_len(input int len, input int max_len);
    if (len < 1) begin
      return 1;
    end
    if (len > max_len) begin
      return max_len;
    end
    return len;
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// Bit-history window: a shift register of the most recent accepted bits
// plus a saturating count of how many bits have arrived since the last flush.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int FILL_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift,
  input  logic               flush,
  input  logic               bit_in,
  output logic [MAX_LEN-1:0] hist,
  output logic [FILL_W-1:0]  fill
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;

  // Flush beats shift so a flushing cycle never leaves the incoming bit behind.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (flush) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      hist_d = {hist_q[MAX_LEN-2:0], bit_in};
      if (fill_q != FILL_W'(MAX_LEN)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // Window state, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist = hist_q;
  assign fill = fill_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial bit-pattern detector. Holds the runtime configuration,
// compares the history window plus the incoming bit against the pattern and
// produces Mealy, Moore and saturating-count match indications.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic               in,
  output logic               mealy_out,
  output logic               moore_out,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               moore_q, moore_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic               accept;
  logic               match;
  logic               flush;

  // A config load takes the whole cycle: the bit offered alongside it is dropped.
  assign accept = in_valid & ~cfg_load;
  assign flush  = cfg_load | (match & ~overlap_q);

  seq_det_window #(
    .MAX_LEN (MAX_LEN),
    .FILL_W  (LEN_W)
  ) u_window (
    .clk    (clk),
    .reset  (reset),
    .shift  (accept),
    .flush  (flush),
    .bit_in (in),
    .hist   (hist),
    .fill   (fill)
  );

  assign cand = {hist[MAX_LEN-2:0], in};

  // Compare only the low len bits of history+incoming bit, once enough bits have arrived.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
    match = accept
          && (int'(fill) >= int'(len_q) - 1)
          && (((cand ^ pattern_q) & mask) == '0);
  end

  // Next-state for config, Moore flag and counter; counter clear outranks a match.
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    moore_d   = moore_q;
    count_d   = count_q;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
      overlap_d = cfg_overlap;
      moore_d   = 1'b0;
    end else if (accept) begin
      moore_d = match;
    end
    if (cnt_clr) begin
      count_d = '0;
    end else if (match && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Registered state; reset restores the legacy 1101 overlapping behaviour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q <= DEF_PATTERN[MAX_LEN-1:0];
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      moore_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      moore_q   <= moore_d;
      count_q   <= count_d;
    end
  end

  assign mealy_out   = match;
  assign moore_out   = moore_q;
  assign match_count = count_q;

endmodule
